// File: rtl/alu_wide_sequencer.sv
// Runs a wide add/logic command through a 16-bit combinational ALU, one word per cycle
// starting with the least significant word, and returns the assembled wide result.
module alu_wide_sequencer #(
  parameter int N_WORDS = 2,
  localparam int W = 16 * N_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CmdValid,
  output logic          CmdReady,
  input  logic [W-1:0]  CmdA,
  input  logic [W-1:0]  CmdB,
  input  logic [3:0]    CmdSel,
  input  logic          CmdMode,
  input  logic          CmdCIn,
  output logic [15:0]   AluA,
  output logic [15:0]   AluB,
  output logic [3:0]    AluSel,
  output logic          AluMode,
  output logic          AluCIn,
  input  logic [15:0]   AluOut,
  input  logic          AluCOut,
  input  logic          AluCmp,
  output logic          RspValid,
  input  logic          RspReady,
  output logic [W-1:0]  RspData,
  output logic          RspCOut,
  output logic          RspEq
);

  localparam int IW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_WORDS-1:0][15:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]               sel_q, sel_d;
  logic                     mode_q, mode_d;
  logic                     carry_q, carry_d;
  logic                     eq_q, eq_d;
  logic                     rsp_cout_q, rsp_cout_d;

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values; the reset clears everything, including the operand words.
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      sel_q      <= '0;
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      eq_q       <= 1'b0;
      rsp_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      carry_q    <= carry_d;
      eq_q       <= eq_d;
      rsp_cout_q <= rsp_cout_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    carry_d    = carry_q;
    eq_d       = eq_q;
    rsp_cout_d = rsp_cout_q;
    AluA       = '0;
    AluB       = '0;
    AluSel     = '0;
    AluMode    = 1'b0;
    AluCIn     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (CmdValid) begin
          a_d     = CmdA;
          b_d     = CmdB;
          sel_d   = CmdSel;
          mode_d  = CmdMode;
          carry_d = CmdCIn;
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        AluA         = a_q[idx_q];
        AluB         = b_q[idx_q];
        AluSel       = sel_q;
        AluMode      = mode_q;
        AluCIn       = carry_q;
        res_d[idx_q] = AluOut;
        carry_d      = AluCOut;
        eq_d         = eq_q & AluCmp;
        // The index wraps to zero on the last word so it never leaves 0..N_WORDS-1.
        if (idx_q == LAST) begin
          idx_d      = '0;
          rsp_cout_d = AluCOut;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (RspReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign CmdReady = (state_q == IDLE);
  assign RspValid = (state_q == DONE);
  assign RspData  = res_q;
  assign RspCOut  = rsp_cout_q;
  assign RspEq    = eq_q;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Bench for alu_wide_sequencer: a behavioural 16-bit ALU closes the loop, and a wide
// arithmetic/bitwise reference model feeds a scoreboard checked by a separate monitor.
module tb_alu_wide_sequencer;

  localparam int N_WORDS = 2;
  localparam int W = 16 * N_WORDS;

  typedef struct packed {
    logic [W-1:0] data;
    logic         cout;
    logic         eq;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          CmdValid, CmdReady;
  logic [W-1:0]  CmdA, CmdB;
  logic [3:0]    CmdSel;
  logic          CmdMode, CmdCIn;
  logic [15:0]   AluA, AluB, AluOut;
  logic [3:0]    AluSel;
  logic          AluMode, AluCIn, AluCOut, AluCmp;
  logic          RspValid, RspReady;
  logic [W-1:0]  RspData;
  logic          RspCOut, RspEq;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  rsp_t exp_q[$];
  int   acc_q[$];
  bit   rdy_rand = 1'b0;
  bit   prev_v = 1'b0;
  rsp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_wide_sequencer #(.N_WORDS(N_WORDS)) dut (
    .clk(clk), .rst(rst),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdA(CmdA), .CmdB(CmdB), .CmdSel(CmdSel), .CmdMode(CmdMode), .CmdCIn(CmdCIn),
    .AluA(AluA), .AluB(AluB), .AluSel(AluSel), .AluMode(AluMode), .AluCIn(AluCIn),
    .AluOut(AluOut), .AluCOut(AluCOut), .AluCmp(AluCmp),
    .RspValid(RspValid), .RspReady(RspReady),
    .RspData(RspData), .RspCOut(RspCOut), .RspEq(RspEq)
  );

  // Bitwise function table of the ALU in logic mode, usable at any width up to 128.
  function automatic logic [127:0] lfn(input logic [127:0] a, input logic [127:0] b,
                                       input logic [3:0] s);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return '0;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return '1;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  // 16-bit ALU: returns {out, cout, cmp}.
  function automatic logic [17:0] alu16(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s, input logic m, input logic c);
    logic [127:0] l;
    logic [15:0]  y;
    logic [16:0]  sum;
    if (m) begin
      l = lfn({112'b0, a}, {112'b0, b}, s);
      return {l[15:0], 2'b00};
    end
    case (s)
      4'b1001: y = b;
      4'b0110: y = ~b;
      4'b1100: y = a;
      default: y = '0;
    endcase
    sum = {1'b0, a} + {1'b0, y} + 17'(c);
    return {sum[15:0], sum[16], a == b};
  endfunction

  always_comb {AluOut, AluCOut, AluCmp} = alu16(AluA, AluB, AluSel, AluMode, AluCIn);

  // Wide reference: whole-operand arithmetic or bitwise result, independent of word slicing.
  function automatic rsp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [3:0] s, input logic m, input logic c);
    rsp_t        r;
    logic [W:0]  sum;
    if (m) begin
      r.data = W'(lfn(128'(a), 128'(b), s));
      r.cout = 1'b0;
      r.eq   = 1'b0;
    end else begin
      case (s)
        4'b1001: sum = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        4'b0110: sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(c);
        4'b1100: sum = {1'b0, a} + {1'b0, a} + (W+1)'(c);
        default: sum = {1'b0, a} + (W+1)'(c);
      endcase
      r.data = sum[W-1:0];
      r.cout = sum[W];
      r.eq   = (a == b);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < N_WORDS; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  // Caller must be #1 after a clock edge.
  task automatic send_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic c, input bit push);
    int n;
    CmdA = a; CmdB = b; CmdSel = s; CmdMode = m; CmdCIn = c;
    CmdValid = 1'b1;
    n = 0;
    while (!CmdReady && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!CmdReady) begin
      fail_now("cmd_accept_timeout");
      CmdValid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) begin
      exp_q.push_back(ref_model(a, b, s, m, c));
      acc_q.push_back(cyc);
    end
    CmdValid = 1'b0;
  endtask

  always begin
    @(posedge clk); #1;
    if (rdy_rand) RspReady = ($urandom_range(0, 3) != 0);
  end

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (CmdReady) check("idle_alu_zero", {AluA, AluB, AluSel, AluMode, AluCIn}, '0);
      if (RspValid) begin
        check("done_cmd_ready_low", CmdReady, 1'b0);
        if (!prev_v) begin
          if (acc_q.size() == 0) fail_now("latency_no_accept");
          else check("latency", cyc - acc_q.pop_front(), N_WORDS);
        end
        if (exp_q.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          mon_e = exp_q[0];
          check("rsp_data", RspData, mon_e.data);
          check("rsp_cout", RspCOut, mon_e.cout);
          check("rsp_eq", RspEq, mon_e.eq);
          if (RspReady) void'(exp_q.pop_front());
        end
      end
      prev_v = RspValid;
    end
  end

  initial begin
    logic [3:0]   arith_sels [4];
    logic [W-1:0] cap, a, b;
    logic [3:0]   s;
    logic         m;
    int           n;
    arith_sels = '{4'b1001, 4'b0110, 4'b1100, 4'b0000};
    CmdValid = 1'b0; CmdA = '0; CmdB = '0; CmdSel = '0; CmdMode = 1'b0; CmdCIn = 1'b0;
    RspReady = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", CmdReady, 1'b1);
    check("rst_rsp_valid", RspValid, 1'b0);
    check("rst_rsp_data", RspData, '0);
    check("rst_rsp_flags", {RspCOut, RspEq}, 2'b00);
    check("rst_alu_bus", {AluA, AluB, AluSel, AluMode, AluCIn}, '0);
    rst = 1'b0;
    RspReady = 1'b1;

    send_cmd(W'(32'h0000FFFF), W'(32'h00000001), 4'b1001, 1'b0, 1'b0, 1'b1);
    send_cmd(W'(32'hFFFFFFFF), W'(32'h00000001), 4'b1001, 1'b0, 1'b0, 1'b1);
    send_cmd(W'(32'h00000000), W'(32'h00000000), 4'b1001, 1'b0, 1'b1, 1'b1);
    send_cmd(W'(32'hF0F0AAAA), W'(32'hFF005555), 4'b0110, 1'b1, 1'b0, 1'b1);
    send_cmd(W'(32'h12345678), W'(32'h12345678), 4'b1001, 1'b0, 1'b0, 1'b1);
    send_cmd(W'(32'h12345679), W'(32'h12345678), 4'b1001, 1'b0, 1'b0, 1'b1);
    send_cmd(W'(32'h22345678), W'(32'h12345678), 4'b1001, 1'b0, 1'b0, 1'b1);

    // Backpressure with a competing command held on the input.
    n = 0;
    while (!CmdReady && n < 50) begin @(posedge clk); #1; n++; end
    RspReady = 1'b0;
    send_cmd(W'(32'h0001FFFF), W'(32'h0000FFFF), 4'b1001, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (!RspValid && n < 50) begin @(posedge clk); #1; n++; end
    if (!RspValid) fail_now("bp_valid_timeout");
    cap = RspData;
    CmdA = W'(32'h00000003); CmdB = W'(32'h00000005); CmdSel = 4'b1001;
    CmdMode = 1'b0; CmdCIn = 1'b0; CmdValid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid_held", RspValid, 1'b1);
      check("bp_data_stable", RspData, cap);
      check("bp_cmd_ready_low", CmdReady, 1'b0);
    end
    RspReady = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", RspValid, 1'b0);
    check("bp_release_idle", CmdReady, 1'b1);
    send_cmd(W'(32'h00000003), W'(32'h00000005), 4'b1001, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a command drops it without a response.
    n = 0;
    while (!CmdReady && n < 50) begin @(posedge clk); #1; n++; end
    send_cmd(W'(32'hAAAA5555), W'(32'h11112222), 4'b1001, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rsp_valid", RspValid, 1'b0);
    check("midrst_cmd_ready", CmdReady, 1'b1);
    check("midrst_rsp_data", RspData, '0);
    check("midrst_rsp_eq", RspEq, 1'b0);
    send_cmd(W'(32'h7FFF8000), W'(32'h00008000), 4'b1001, 1'b0, 1'b0, 1'b1);

    // Random traffic with random response backpressure.
    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      m = 1'($urandom_range(0, 1));
      s = m ? 4'($urandom_range(0, 15)) : arith_sels[$urandom_range(0, 3)];
      a = rand_w();
      b = ($urandom_range(0, 3) == 0) ? a : rand_w();
      send_cmd(a, b, s, m, 1'($urandom_range(0, 1)), 1'b1);
    end

    rdy_rand = 1'b0;
    RspReady = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
